// File: rtl/systema_cpu_debug_ocimem_ctrl.sv
// Debug-side memory access engine: decodes ocimem strobes from the debug slave
// and performs single-word reads/writes on an Avalon-MM style master port.
module systema_cpu_debug_ocimem_ctrl #(
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int RESET_ADDR     = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_t;

  localparam logic [7:0]        TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] PTR_RST = ADDR_W'(RESET_ADDR);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [7:0]        wait_cnt;
  logic              any_strobe;
  logic              unused_jdo;

  assign any_strobe  = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign unused_jdo  = ^jdo;
  assign mem_address = ptr;
  assign dbg_state   = state;

  // Master handshake: a request (mem_read or mem_write) is held with stable
  // address/data until a cycle where mem_waitrequest is low; that cycle is the
  // transfer. Read data is sampled only in that cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      ptr           <= PTR_RST;
      wait_cnt      <= 8'd0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_writedata <= 32'd0;
      MonDReg       <= 32'd0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take_action_ocimem_a) begin
            if (jdo[35]) ptr <= jdo[ADDR_W+1:2];
            if (jdo[34]) begin
              state         <= ST_RD;
              mem_read      <= 1'b1;
              wait_cnt      <= 8'd0;
              monitor_ready <= 1'b0;
              monitor_error <= 1'b0;
            end
            // Losing strobes are reported even when the winner is a no-op.
            if (take_action_ocimem_b || take_no_action_ocimem_a) monitor_error <= 1'b1;
          end else if (take_action_ocimem_b) begin
            state         <= ST_WR;
            mem_write     <= 1'b1;
            mem_writedata <= jdo[34:3];
            wait_cnt      <= 8'd0;
            monitor_ready <= 1'b0;
            monitor_error <= take_no_action_ocimem_a;
          end else if (take_no_action_ocimem_a) begin
            state         <= ST_RD;
            mem_read      <= 1'b1;
            wait_cnt      <= 8'd0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
          end
        end
        ST_RD, ST_WR: begin
          if (any_strobe) monitor_error <= 1'b1;
          if (!mem_waitrequest) begin
            MonDReg       <= (state == ST_RD) ? mem_readdata : mem_writedata;
            ptr           <= ptr + 1'b1;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            monitor_ready <= 1'b1;
            state         <= ST_IDLE;
          end else if (wait_cnt == TO_LAST) begin
            // Abort leaves ptr and MonDReg untouched.
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b1;
            state         <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule
